// File: rtl/bell_pkg.sv
// Shared types and constants for the buzzer sequencer: FSM state encoding,
// default durations and the BCD-hour to chime-count conversion.
package bell_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RING      = 3'd1,
        SNOOZE    = 3'd2,
        CHIME_ON  = 3'd3,
        CHIME_OFF = 3'd4
    } bellState_t;

    localparam int RING_SECS_DEF   = 60;
    localparam int SNOOZE_SECS_DEF = 300;
    localparam int MAX_SNOOZE_DEF  = 3;

    // Hour 00 and anything above 12 (including bad BCD digits) chime twelve times.
    function automatic logic [3:0] bcd_hour_to_count(input logic [3:0] hourH,
                                                     input logic [3:0] hourL);
        logic [7:0] v;
        v = 8'(hourH) * 8'd10 + 8'(hourL);
        if (v == 8'd0 || v > 8'd12) return 4'd12;
        return v[3:0];
    endfunction

endpackage

// File: rtl/bell_sched_if.sv
// Request/status bundle between the clock's alarm, timebase and key logic
// (master) and the buzzer sequencer (slave).
interface bell_sched_if;
    logic       Tick;
    logic       BellEn;
    logic       SetBellMode;
    logic       AlarmMatch;
    logic       HourTop;
    logic [3:0] HourH;
    logic [3:0] HourL;
    logic       StopKey;
    logic       SnoozeKey;
    logic       Buzzer;
    logic       Ringing;
    logic       Snoozing;
    logic       Chiming;
    logic [1:0] SnoozeCnt;

    modport master (
        output Tick, BellEn, SetBellMode, AlarmMatch, HourTop, HourH, HourL,
               StopKey, SnoozeKey,
        input  Buzzer, Ringing, Snoozing, Chiming, SnoozeCnt
    );

    modport slave (
        input  Tick, BellEn, SetBellMode, AlarmMatch, HourTop, HourH, HourL,
               StopKey, SnoozeKey,
        output Buzzer, Ringing, Snoozing, Chiming, SnoozeCnt
    );
endinterface

// File: rtl/bell_timer.sv
// Loadable down-counter advanced by the 1 Hz tick; expire flags the tick that
// takes the count from 1 to 0. A load in the same cycle wins over the tick.
module bell_timer #(
    parameter int W = 9
) (
    input  logic         CP,
    input  logic         CR,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (tick && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = tick && (count == W'(1));

endmodule

// File: rtl/bell_sched.sv
// Buzzer owner: arbitrates the alarm (ring/snooze/stop) against the hourly
// chime and drives the speaker enable plus status flags.
//
//   state     | meaning
//   IDLE      | buzzer free, waiting for alarm edge or top of hour
//   RING      | alarm sounding, timer counts the ring timeout
//   SNOOZE    | alarm silenced, timer counts down to the next ring
//   CHIME_ON  | hourly chime, beep audible for one tick period
//   CHIME_OFF | hourly chime, gap of one tick period; beep count decremented
module bell_sched
    import bell_pkg::*;
#(
    parameter int RING_SECS   = RING_SECS_DEF,
    parameter int SNOOZE_SECS = SNOOZE_SECS_DEF,
    parameter int MAX_SNOOZE  = MAX_SNOOZE_DEF
) (
    input  logic         CP,
    input  logic         CR,
    bell_sched_if.slave  bus
);

    localparam int TMAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int TW   = $clog2(TMAX + 1);

    bellState_t    state, stateNext;
    logic [1:0]    snoozeCnt, snoozeCntNext;
    logic [3:0]    nCnt, nCntNext;
    logic          matchD;
    logic          armed;
    logic          trigger;
    logic          timerLoad;
    logic [TW-1:0] timerVal;
    logic          expire;

    bell_timer #(.W(TW)) uTimer (
        .CP      (CP),
        .CR      (CR),
        .tick    (bus.Tick),
        .load    (timerLoad),
        .loadVal (timerVal),
        .expire  (expire)
    );

    // armed blocks a false edge when AlarmMatch is already high out of reset.
    assign trigger = bus.AlarmMatch && !matchD && armed && bus.BellEn && !bus.SetBellMode;

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state     <= IDLE;
            snoozeCnt <= 2'd0;
            nCnt      <= 4'd0;
            matchD    <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= stateNext;
            snoozeCnt <= snoozeCntNext;
            nCnt      <= nCntNext;
            matchD    <= bus.AlarmMatch;
            armed     <= armed || !bus.AlarmMatch;
        end
    end

    always_comb begin
        stateNext     = state;
        snoozeCntNext = snoozeCnt;
        nCntNext      = nCnt;
        timerLoad     = 1'b0;
        timerVal      = TW'(RING_SECS);
        case (state)
            IDLE: begin
                if (trigger) begin
                    stateNext     = RING;
                    timerLoad     = 1'b1;
                    snoozeCntNext = 2'd0;
                end else if (bus.HourTop && !bus.SetBellMode) begin
                    stateNext = CHIME_ON;
                    nCntNext  = bcd_hour_to_count(bus.HourH, bus.HourL);
                    timerLoad = 1'b1;
                    timerVal  = TW'(1);
                end
            end
            RING: begin
                if (!bus.BellEn || bus.SetBellMode || bus.StopKey) begin
                    stateNext = IDLE;
                end else if (bus.SnoozeKey) begin
                    if (int'(snoozeCnt) < MAX_SNOOZE) begin
                        stateNext     = SNOOZE;
                        timerLoad     = 1'b1;
                        timerVal      = TW'(SNOOZE_SECS);
                        snoozeCntNext = snoozeCnt + 2'd1;
                    end else begin
                        stateNext = IDLE;
                    end
                end else if (expire) begin
                    stateNext = IDLE;
                end
            end
            SNOOZE: begin
                if (!bus.BellEn || bus.SetBellMode || bus.StopKey) begin
                    stateNext = IDLE;
                end else if (expire) begin
                    stateNext = RING;
                    timerLoad = 1'b1;
                end
            end
            CHIME_ON, CHIME_OFF: begin
                if (trigger) begin
                    stateNext     = RING;
                    timerLoad     = 1'b1;
                    snoozeCntNext = 2'd0;
                end else if (bus.SetBellMode || bus.StopKey) begin
                    stateNext = IDLE;
                end else if (expire) begin
                    timerLoad = 1'b1;
                    timerVal  = TW'(1);
                    if (state == CHIME_ON) begin
                        stateNext = CHIME_OFF;
                    end else begin
                        nCntNext  = nCnt - 4'd1;
                        stateNext = (nCnt <= 4'd1) ? IDLE : CHIME_ON;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.Buzzer    = (state == RING) || (state == CHIME_ON);
    assign bus.Ringing   = (state == RING);
    assign bus.Snoozing  = (state == SNOOZE);
    assign bus.Chiming   = (state == CHIME_ON) || (state == CHIME_OFF);
    assign bus.SnoozeCnt = snoozeCnt;

endmodule

// File: tb/tb_bell_sched.sv
// Directed bench for bell_sched: ring timeout, snooze limit, hourly chime,
// alarm/chime priority, bell-set suppression and asynchronous reset.
module tb_bell_sched;

    logic CP = 1'b0;
    logic CR = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic sawRing;

    bell_sched_if bus ();

    bell_sched dut (
        .CP  (CP),
        .CR  (CR),
        .bus (bus.slave)
    );

    always #5 CP = ~CP;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CP);
        #1;
    endtask

    task automatic tickPulse();
        bus.Tick = 1'b1;
        cyc();
        bus.Tick = 1'b0;
        if (bus.Ringing) sawRing = 1'b1;
        cyc();
        if (bus.Ringing) sawRing = 1'b1;
    endtask

    task automatic pulseSnooze();
        bus.SnoozeKey = 1'b1;
        cyc();
        bus.SnoozeKey = 1'b0;
    endtask

    task automatic pulseStop();
        bus.StopKey = 1'b1;
        cyc();
        bus.StopKey = 1'b0;
    endtask

    task automatic runChime(input logic [3:0] h, input logic [3:0] l, input int expBeeps,
                            input string tag);
        int   beeps;
        int   nTicks;
        logic prev;
        bus.HourH   = h;
        bus.HourL   = l;
        bus.HourTop = 1'b1;
        cyc();
        bus.HourTop = 1'b0;
        bus.HourL   = 4'd3;
        chk({tag, "_start"}, {31'd0, bus.Chiming}, 32'd1);
        beeps  = bus.Buzzer ? 1 : 0;
        prev   = bus.Buzzer;
        nTicks = 0;
        while (bus.Chiming && nTicks < 40) begin
            tickPulse();
            nTicks++;
            if (bus.Buzzer && !prev) beeps++;
            prev = bus.Buzzer;
        end
        chk({tag, "_beeps"}, beeps, expBeeps);
        chk({tag, "_ticks"}, nTicks, 2 * expBeeps);
        chk({tag, "_done"}, {31'd0, bus.Chiming}, 32'd0);
    endtask

    initial begin
        bus.Tick        = 1'b0;
        bus.BellEn      = 1'b0;
        bus.SetBellMode = 1'b0;
        bus.AlarmMatch  = 1'b0;
        bus.HourTop     = 1'b0;
        bus.HourH       = 4'd0;
        bus.HourL       = 4'd0;
        bus.StopKey     = 1'b0;
        bus.SnoozeKey   = 1'b0;
        sawRing         = 1'b0;

        cyc();
        cyc();
        chk("rst_buzzer", {31'd0, bus.Buzzer}, 32'd0);
        chk("rst_flags", {29'd0, bus.Ringing, bus.Snoozing, bus.Chiming}, 32'd0);
        chk("rst_snoozecnt", {30'd0, bus.SnoozeCnt}, 32'd0);
        CR = 1'b0;
        cyc();

        // Ring timeout, then no retrigger while match level is held.
        bus.BellEn     = 1'b1;
        bus.AlarmMatch = 1'b1;
        cyc();
        chk("ring_start", {30'd0, bus.Buzzer, bus.Ringing}, 32'd3);
        repeat (59) tickPulse();
        chk("ring_tick59", {31'd0, bus.Ringing}, 32'd1);
        tickPulse();
        chk("ring_tick60", {30'd0, bus.Buzzer, bus.Ringing}, 32'd0);
        sawRing = 1'b0;
        repeat (60) tickPulse();
        chk("ring_no_retrigger", {31'd0, sawRing}, 32'd0);
        bus.AlarmMatch = 1'b0;
        cyc();

        // Three snoozes re-ring; the fourth press behaves as stop.
        bus.AlarmMatch = 1'b1;
        cyc();
        chk("snz_ring", {31'd0, bus.Ringing}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            pulseSnooze();
            chk("snz_enter", {30'd0, bus.Snoozing, bus.Buzzer}, 32'd2);
            chk("snz_cnt", {30'd0, bus.SnoozeCnt}, i);
            repeat (299) tickPulse();
            chk("snz_tick299", {31'd0, bus.Snoozing}, 32'd1);
            tickPulse();
            chk("snz_rering", {30'd0, bus.Ringing, bus.Buzzer}, 32'd3);
        end
        pulseSnooze();
        chk("snz_limit_idle", {30'd0, bus.Ringing, bus.Snoozing}, 32'd0);
        chk("snz_limit_cnt", {30'd0, bus.SnoozeCnt}, 32'd3);
        bus.AlarmMatch = 1'b0;
        cyc();

        // Hourly chimes; later hour changes must not alter the captured count.
        runChime(4'd0, 4'd7, 7, "chime7");
        runChime(4'd0, 4'd0, 12, "chime00");
        runChime(4'd1, 4'd1, 11, "chime11");
        runChime(4'd1, 4'd5, 12, "chime15");

        // Alarm edge aborts a chime in progress; HourTop during ring ignored.
        bus.HourH   = 4'd0;
        bus.HourL   = 4'd9;
        bus.HourTop = 1'b1;
        cyc();
        bus.HourTop = 1'b0;
        repeat (4) tickPulse();
        chk("abort_beat3", {30'd0, bus.Chiming, bus.Buzzer}, 32'd3);
        bus.AlarmMatch = 1'b1;
        cyc();
        chk("abort_ring", {29'd0, bus.Ringing, bus.Chiming, bus.Buzzer}, 32'd5);
        bus.HourTop = 1'b1;
        cyc();
        bus.HourTop = 1'b0;
        chk("hourtop_in_ring", {30'd0, bus.Ringing, bus.Chiming}, 32'd2);
        pulseStop();
        repeat (3) tickPulse();
        chk("abort_no_resume", {29'd0, bus.Ringing, bus.Chiming, bus.Buzzer}, 32'd0);
        bus.AlarmMatch = 1'b0;
        cyc();

        // Bell-set mode cancels a ring and blocks a new one.
        bus.AlarmMatch = 1'b1;
        cyc();
        chk("set_ring", {31'd0, bus.Ringing}, 32'd1);
        bus.SetBellMode = 1'b1;
        cyc();
        chk("set_cancel", {31'd0, bus.Ringing}, 32'd0);
        bus.AlarmMatch = 1'b0;
        cyc();
        bus.AlarmMatch = 1'b1;
        cyc();
        cyc();
        chk("set_blocks", {31'd0, bus.Ringing}, 32'd0);
        bus.SetBellMode = 1'b0;
        bus.AlarmMatch  = 1'b0;
        cyc();

        // BellEn drop cancels a ring; Stop beats a simultaneous Snooze.
        bus.AlarmMatch = 1'b1;
        cyc();
        bus.BellEn = 1'b0;
        cyc();
        chk("disable_cancel", {31'd0, bus.Ringing}, 32'd0);
        bus.BellEn     = 1'b1;
        bus.AlarmMatch = 1'b0;
        cyc();
        bus.AlarmMatch = 1'b1;
        cyc();
        bus.StopKey   = 1'b1;
        bus.SnoozeKey = 1'b1;
        cyc();
        bus.StopKey   = 1'b0;
        bus.SnoozeKey = 1'b0;
        chk("stop_wins", {30'd0, bus.Ringing, bus.Snoozing}, 32'd0);
        bus.AlarmMatch = 1'b0;
        cyc();

        // Asynchronous reset mid-snooze, released with the match still high.
        bus.AlarmMatch = 1'b1;
        cyc();
        pulseSnooze();
        chk("pre_rst_snooze", {31'd0, bus.Snoozing}, 32'd1);
        #2;
        CR = 1'b1;
        #1;
        chk("async_rst_flags", {28'd0, bus.Buzzer, bus.Ringing, bus.Snoozing, bus.Chiming}, 32'd0);
        chk("async_rst_cnt", {30'd0, bus.SnoozeCnt}, 32'd0);
        cyc();
        CR = 1'b0;
        repeat (3) cyc();
        chk("rst_release_high", {31'd0, bus.Ringing}, 32'd0);
        bus.AlarmMatch = 1'b0;
        cyc();
        bus.AlarmMatch = 1'b1;
        cyc();
        chk("rearm_ring", {31'd0, bus.Ringing}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
